fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address after reset; bits [1:0] SHALL be treated as 00.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address; bits [1:0] SHALL always be 00.
REQ-006 imem_valid  input  1  response strobe; imem_rdata valid this cycle; only meaningful while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 stall  input  1  downstream (decode/controller) cannot accept the held instruction.
REQ-009 branch_taken  input  1  redirect/flush request, one-cycle pulse or level.
REQ-010 branch_target  input  32  redirect address; bits [1:0] ignored.
REQ-011 inst_valid  output  1  instr and decoded fields valid.
REQ-012 instr  output  32  registered instruction word.
REQ-013 opcode / func  output  6 / 6  instr[31:26] / instr[5:0], feeding the controller's opcode and func inputs.
REQ-014 rs / rt / rd  output  5 each  instr[25:21] / [20:16] / [15:11].
REQ-015 imm  output  16  instr[15:0].
REQ-016 pc_plus4  output  32  address of instr plus 4, registered with instr.

Function
REQ-017 Internal state SHALL comprise: pc register, output register (instr, pc_plus4, inst_valid), one-entry skid buffer (word, pc_plus4, skid_valid), target latch, FSM {IDLE, REQ, DRAIN, FULL}.
REQ-018 Handoff SHALL occur on any cycle with inst_valid=1 and stall=0; while stall=1 all instruction outputs SHALL hold stable.
REQ-019 Slot free SHALL mean inst_valid=0 or handoff this cycle; skid data SHALL move to the output register before any new response.
REQ-020 IDLE: imem_req=0; next state REQ unconditionally.
REQ-021 REQ: imem_req=1, imem_addr=pc; imem_addr SHALL stay constant until the cycle imem_valid=1.
REQ-022 REQ with imem_valid=1 and branch_taken=0: word SHALL go to output register if slot free (and skid empty), else to skid; pc SHALL become pc+4 (wrapping 32'hFFFF_FFFC -> 0); next state FULL if skid_valid=1 after the edge, else REQ.
REQ-023 Zero-wait memory (imem_valid every REQ cycle) with stall=0 SHALL yield one instruction per cycle.
REQ-024 FULL: imem_req=0; return to REQ on the edge at which skid drains to the output register.
REQ-025 branch_taken=1 in any state SHALL clear inst_valid and skid_valid at the next edge.
REQ-026 branch_taken in REQ with imem_valid=1 same cycle: response discarded, pc<=target, stay REQ.
REQ-027 branch_taken in REQ with imem_valid=0: target latched, next state DRAIN.
REQ-028 DRAIN: imem_req=1 with the old address; response on imem_valid discarded; then pc<=latched target, next state REQ; a further branch_taken in DRAIN SHALL overwrite the latch (last wins).
REQ-029 branch_taken in IDLE or FULL: pc<=target, next state REQ.
REQ-030 branch_taken and stall high together: branch SHALL win; no instruction handed off.
REQ-031 No discarded or flushed word SHALL ever appear with inst_valid=1.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, skid_valid=0, instr=0, pc_plus4=0, all field outputs 0.
REQ-033 Reset asserted mid-request SHALL abandon the request; first imem_req=1 SHALL appear one cycle after rst_n rises.

Verification
REQ-034 Reset release, zero-wait memory returning 32'h0000_0000-pattern R-types (opcode 000000, func 100000/100010/100100/100101), stall=0 -> addresses 0,4,8,12 on consecutive cycles; matching func at controller one cycle after each response.
REQ-035 lw 32'h8C22_0004 fetched, stall held 3 cycles -> opcode=100011, rs=1, rt=2, imm=0004 stable all 3 cycles; next word from skid with no bubble, FULL entered and exited, req low while FULL.
REQ-036 Memory 3-cycle latency, branch_taken at cycle 1 of request to 8 with target 32'h0000_0040 -> DRAIN, stale word discarded, next imem_addr=32'h40, inst_valid never high for addr 8.
REQ-037 beq 32'h1022_FFFE held with stall=1, branch_taken=1 same cycle -> inst_valid=0 next cycle, skid cleared, next fetch at target.
REQ-038 pc at 32'hFFFF_FFFC, response returned -> next imem_addr=0, pc_plus4=0.
REQ-039 rst_n pulsed low during DRAIN -> all outputs reset asynchronously; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned reads, registers the returned
// instruction with its decoded fields, absorbs one extra response in a skid
// buffer when decode stalls, and flushes/redirects on branch_taken.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc_plus4
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] skid_word_q, skid_word_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] instr_d, pc4_d;
  logic            valid_d;
  logic            req_d;

  logic            handoff;
  logic            slot_free;
  logic            accept;
  logic [XLEN-1:0] target_al;
  logic [XLEN-1:0] pc_next;

  // Handshake qualifiers shared by the next-state logic
  assign handoff   = inst_valid & ~stall;
  assign slot_free = ~inst_valid | handoff;
  assign accept    = (state_q == REQ) & imem_valid & ~branch_taken;
  assign target_al = branch_target & ALIGN_MASK;
  assign pc_next   = pc_q + WORD_BYTES;

  // Next-state, datapath and request computation
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_word_d  = skid_word_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;
    instr_d      = instr;
    pc4_d        = pc_plus4;
    valid_d      = inst_valid;

    if (handoff) begin
      valid_d = 1'b0;
    end

    // Skid contents always reach the output ahead of a fresh response
    if (slot_free && skid_valid_q) begin
      instr_d      = skid_word_q;
      pc4_d        = skid_pc4_q;
      valid_d      = 1'b1;
      skid_valid_d = 1'b0;
    end

    if (accept) begin
      if (slot_free && !skid_valid_q) begin
        instr_d = imem_rdata;
        pc4_d   = pc_next;
        valid_d = 1'b1;
      end else begin
        skid_word_d  = imem_rdata;
        skid_pc4_d   = pc_next;
        skid_valid_d = 1'b1;
      end
      pc_d = pc_next;
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (accept) begin
          state_d = skid_valid_d ? FULL : REQ;
        end else if (branch_taken && imem_valid) begin
          pc_d    = target_al;
          state_d = REQ;
        end else if (branch_taken) begin
          tgt_d   = target_al;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The outstanding read must complete before the new address is issued
        if (imem_valid) begin
          pc_d    = branch_taken ? target_al : tgt_q;
          state_d = REQ;
        end else if (branch_taken) begin
          tgt_d = target_al;
        end
      end
      FULL: begin
        if (slot_free) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect flushes everything held; IDLE/FULL have no read in flight
    if (branch_taken) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      if (state_q == IDLE || state_q == FULL) begin
        pc_d    = target_al;
        state_d = REQ;
      end
    end

    req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC & ALIGN_MASK;
      tgt_q        <= '0;
      skid_word_q  <= '0;
      skid_pc4_q   <= '0;
      skid_valid_q <= 1'b0;
      instr        <= '0;
      pc_plus4     <= '0;
      inst_valid   <= 1'b0;
      imem_req     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_word_q  <= skid_word_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
      instr        <= instr_d;
      pc_plus4     <= pc4_d;
      inst_valid   <= valid_d;
      imem_req     <= req_d;
    end
  end

  // Fetch address and decoded fields are direct views of registers
  assign imem_addr = pc_q;
  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign func      = instr[5:0];
  assign imm       = instr[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-configurable memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] pc_plus4;

  int errors = 0;
  int checks = 0;
  int lat    = 0;
  int wait_cnt;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .instr         (instr),
    .opcode        (opcode),
    .func          (func),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .imm           (imm),
    .pc_plus4      (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0020;
      32'h0000_0004: return 32'h0000_0022;
      32'h0000_0008: return 32'h0000_0024;
      32'h0000_000C: return 32'h0000_0025;
      32'h0000_0010: return 32'h8C22_0004;
      32'h0000_0014: return 32'h1022_FFFE;
      32'h0000_0040: return 32'h2001_0040;
      32'hFFFF_FFFC: return 32'hAC22_0008;
      default:       return a ^ 32'h3C00_0000;
    endcase
  endfunction

  // Memory answers after 'lat' extra cycles of a held request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always_comb begin
    imem_valid = imem_req && (wait_cnt >= lat);
    imem_rdata = mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    lat = 0;
    tick();
    tick();

    // Reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc4", pc_plus4, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_fields", {opcode, func, rs, rt, rd}, 32'd0);

    rst_n = 1'b1;
    check("rel_req_low", 32'(imem_req), 32'd0);

    // Zero-wait stream of R-types
    tick();
    check("s0_req", 32'(imem_req), 32'd1);
    check("s0_addr", imem_addr, 32'h0);
    check("s0_valid", 32'(inst_valid), 32'd0);
    tick();
    check("s1_addr", imem_addr, 32'h4);
    check("s1_func", 32'(func), 32'h20);
    check("s1_op", 32'(opcode), 32'h0);
    check("s1_pc4", pc_plus4, 32'h4);
    tick();
    check("s2_addr", imem_addr, 32'h8);
    check("s2_func", 32'(func), 32'h22);
    tick();
    check("s3_addr", imem_addr, 32'hC);
    check("s3_func", 32'(func), 32'h24);
    tick();
    check("s4_addr", imem_addr, 32'h10);
    check("s4_func", 32'(func), 32'h25);
    check("s4_valid", 32'(inst_valid), 32'd1);

    // lw held under stall, beq absorbed by skid
    tick();
    check("lw_op", 32'(opcode), 32'h23);
    check("lw_addr", imem_addr, 32'h14);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_hold_op", 32'(opcode), 32'h23);
      check("lw_hold_rs", 32'(rs), 32'd1);
      check("lw_hold_rt", 32'(rt), 32'd2);
      check("lw_hold_imm", 32'(imm), 32'h4);
      check("lw_hold_valid", 32'(inst_valid), 32'd1);
      check("full_req_low", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    check("skid_instr", instr, 32'h1022_FFFE);
    check("skid_valid", 32'(inst_valid), 32'd1);
    check("skid_pc4", pc_plus4, 32'h18);
    check("full_exit_req", 32'(imem_req), 32'd1);
    check("full_exit_addr", imem_addr, 32'h18);

    // beq held with stall, skid filled, then branch while stalled
    stall = 1'b1;
    tick();
    check("beq_hold", instr, 32'h1022_FFFE);
    check("beq_full_req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0040;
    tick();
    check("br_stall_valid", 32'(inst_valid), 32'd0);
    check("br_stall_addr", imem_addr, 32'h40);
    check("br_stall_req", 32'(imem_req), 32'd1);
    branch_taken = 1'b0;
    stall = 1'b0;
    tick();
    check("br_tgt_instr", instr, 32'h2001_0040);
    check("br_tgt_pc4", pc_plus4, 32'h44);
    check("br_tgt_valid", 32'(inst_valid), 32'd1);

    // Slow memory: redirect to 8 through DRAIN
    lat = 2;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0008;
    tick();
    check("drain_req", 32'(imem_req), 32'd1);
    check("drain_addr", imem_addr, 32'h44);
    check("drain_valid", 32'(inst_valid), 32'd0);
    branch_taken = 1'b0;
    for (int i = 0; i < 8 && imem_addr == 32'h44; i++) tick();
    check("redir8_addr", imem_addr, 32'h8);

    // Branch at first cycle of request to 8; second branch in DRAIN wins
    branch_taken = 1'b1;
    branch_target = 32'h0000_0080;
    tick();
    check("d2_addr", imem_addr, 32'h8);
    check("d2_req", 32'(imem_req), 32'd1);
    branch_target = 32'h0000_0040;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 8 && imem_addr == 32'h8; i++) begin
      tick();
      check("stale_never_valid", 32'(inst_valid), 32'd0);
    end
    check("last_wins_addr", imem_addr, 32'h40);
    for (int i = 0; i < 8 && !inst_valid; i++) tick();
    check("after_drain_valid", 32'(inst_valid), 32'd1);
    check("after_drain_instr", instr, 32'h2001_0040);
    check("after_drain_pc4", pc_plus4, 32'h44);

    // Wrap at top of address space; low target bits ignored
    lat = 0;
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_valid", 32'(inst_valid), 32'd0);
    branch_taken = 1'b0;
    tick();
    check("wrap_instr", instr, 32'hAC22_0008);
    check("wrap_pc4", pc_plus4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    tick();
    check("wrap_next", instr, 32'h0000_0020);
    check("wrap_next_pc4", pc_plus4, 32'h4);

    // Async reset in the middle of DRAIN
    lat = 3;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    check("d3_req", 32'(imem_req), 32'd1);
    check("d3_addr", imem_addr, 32'h4);
    branch_taken = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_valid", 32'(inst_valid), 32'd0);
    check("async_instr", instr, 32'd0);
    check("async_pc4", pc_plus4, 32'd0);
    check("async_addr", imem_addr, 32'd0);
    check("async_imm", 32'(imm), 32'd0);
    tick();
    lat = 0;
    rst_n = 1'b1;
    check("rel2_req_low", 32'(imem_req), 32'd0);
    tick();
    check("rel2_req", 32'(imem_req), 32'd1);
    check("rel2_addr", imem_addr, 32'h0);
    tick();
    check("rel2_instr", instr, 32'h0000_0020);
    check("rel2_valid", 32'(inst_valid), 32'd1);
    check("rel2_pc4", pc_plus4, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
